// File: rtl/ofm_wr_feeder_pkg.sv
// ofm_wr_feeder_pkg: shared FSM encoding and sizing constants for the OFM write feeder
package ofm_wr_feeder_pkg;
  typedef enum logic [2:0] {IDLE, FILL, LAUNCH, XFER, FIN} state_e;
  localparam int CHUNK_DEF = 256;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/ofm_word_fifo.sv
// ofm_word_fifo: show-ahead word FIFO with push/pop/count; head reads 0 when empty
module ofm_word_fifo #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [AW:0]   count_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign dout_o  = cnt_q == '0 ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/ofm_wr_feeder.sv
// ofm_wr_feeder: packs pixels into words and launches chunked AXI write DMA transfers.
// Define OFM_FEEDER_UNDERRUN_CHK_EN to guard pops on an empty FIFO with a sticky underrun_err.
module ofm_wr_feeder
  import ofm_wr_feeder_pkg::*;
#(
  parameter int AXI_WIDTH_AD   = 32,
  parameter int AXI_WIDTH_DA   = 32,
  parameter int OUT_BITS_TRANS = 13,
  parameter int FIFO_AW        = 9,
  parameter int CHUNK          = CHUNK_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [AXI_WIDTH_AD-1:0]   cfg_base_addr,
  input  logic [15:0]               cfg_total_words,
  input  logic                      px_valid,
  input  logic [7:0]                px_data,
  output logic                      px_ready,
  output logic                      start_dma,
  output logic [OUT_BITS_TRANS-1:0] num_trans,
  output logic [AXI_WIDTH_AD-1:0]   start_addr,
  input  logic                      dma_done,
  input  logic                      indata_req,
  output logic [AXI_WIDTH_DA-1:0]   indata,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      underrun_err
);
  state_e                  state_q;
  logic [AXI_WIDTH_AD-1:0] addr_q;
  logic [15:0]             rem_q, total_q, chunk;
  logic [17:0]             acc_q;
  logic [1:0]              bcnt_q;
  logic [AXI_WIDTH_DA-1:0] sr_q;
  logic                    push_q, pop, take, start;
  logic [FIFO_AW:0]        count;
  assign busy     = state_q != IDLE;
  assign start    = state_q == IDLE && cfg_start;
  assign chunk    = rem_q < 16'(CHUNK) ? rem_q : 16'(CHUNK);
  assign px_ready = busy && count <= (FIFO_AW+1)'(2**FIFO_AW - 2) && acc_q < {total_q, 2'b00};
  assign take     = px_valid && px_ready;
`ifdef OFM_FEEDER_UNDERRUN_CHK_EN
  logic underrun_q;
  assign pop = indata_req && count != '0;
  always_ff @(posedge clk)
    if (rst || start) underrun_q <= 1'b0;
    else if (indata_req && count == '0) underrun_q <= 1'b1;
  assign underrun_err = underrun_q;
`else
  assign pop          = indata_req;
  assign underrun_err = 1'b0;
`endif
  ofm_word_fifo #(.DW(AXI_WIDTH_DA), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push_q), .din_i(sr_q),
    .pop_i(pop), .dout_o(indata), .count_o(count)
  );
  // Little-endian packing: each byte shifts in at the top, so byte 0 lands in [7:0] after four
  always_ff @(posedge clk) begin
    if (rst || start) begin
      acc_q  <= '0;
      bcnt_q <= '0;
      sr_q   <= '0;
      push_q <= 1'b0;
    end else begin
      push_q <= take && bcnt_q == 2'(BYTES_PER_WORD - 1);
      if (take) begin
        acc_q  <= acc_q + 18'd1;
        bcnt_q <= bcnt_q + 2'd1;
        sr_q   <= {px_data, sr_q[AXI_WIDTH_DA-1:8]};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      total_q    <= '0;
      start_dma  <= 1'b0;
      frame_done <= 1'b0;
      num_trans  <= '0;
      start_addr <= '0;
    end else begin
      start_dma  <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        IDLE: if (cfg_start) begin
          addr_q     <= cfg_base_addr;
          rem_q      <= cfg_total_words;
          total_q    <= cfg_total_words;
          state_q    <= cfg_total_words == '0 ? FIN : FILL;
          frame_done <= cfg_total_words == '0;
        end
        FILL: if (16'(count) >= chunk) begin
          state_q    <= LAUNCH;
          start_dma  <= 1'b1;
          num_trans  <= OUT_BITS_TRANS'(chunk);
          start_addr <= addr_q;
        end
        LAUNCH: state_q <= XFER;
        XFER: if (dma_done) begin
          addr_q     <= addr_q + AXI_WIDTH_AD'({chunk, 2'b00});
          rem_q      <= rem_q - chunk;
          state_q    <= rem_q == chunk ? FIN : FILL;
          frame_done <= rem_q == chunk;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofm_wr_feeder.sv
// tb_ofm_wr_feeder: directed self-checking bench for ofm_wr_feeder
module tb_ofm_wr_feeder;
  logic        clk = 1'b0;
  logic        rst, cfg_start, px_valid, dma_done, indata_req;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_total_words;
  logic [7:0]  px_data;
  logic        px_ready, start_dma, busy, frame_done, underrun_err;
  logic [12:0] num_trans;
  logic [31:0] start_addr, indata;

  int errors = 0, checks = 0;
  int acc_bytes, words_popped, bad_words, n_launch, n_done, stall_bytes;
  bit stall_seen;
  logic [12:0] l_num [8];
  logic [31:0] l_addr [8];

  ofm_wr_feeder dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_total_words(cfg_total_words), .px_valid(px_valid), .px_data(px_data),
    .px_ready(px_ready), .start_dma(start_dma), .num_trans(num_trans),
    .start_addr(start_addr), .dma_done(dma_done), .indata_req(indata_req),
    .indata(indata), .busy(busy), .frame_done(frame_done), .underrun_err(underrun_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int k);
    return 8'(k * 7 + 3);
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    return {pix(4*w+3), pix(4*w+2), pix(4*w+1), pix(4*w)};
  endfunction

  task automatic wait_launch(input string tag);
    for (int c = 0; c < 40 && !start_dma; c++) tick();
    check(tag, 32'(start_dma), 32'd1);
  endtask

  // Streams one byte per cycle and behaves as the DMA; hold_full delays pops until intake stalls
  task automatic run_frame(input int total, input logic [31:0] base, input bit hold_full);
    int words_left;
    bit done_pending, acc_inc;
    acc_bytes = 0; words_popped = 0; bad_words = 0; n_launch = 0; n_done = 0;
    stall_seen = 0; stall_bytes = 0; words_left = 0; done_pending = 0;
    cfg_start = 1; cfg_total_words = 16'(total); cfg_base_addr = base;
    tick();
    cfg_start = 0;
    for (int cyc = 0; cyc < 20000 && n_done == 0; cyc++) begin
      px_valid = 1;
      px_data = pix(acc_bytes);
      dma_done = done_pending;
      done_pending = 0;
      if (start_dma) begin
        if (n_launch < 8) begin
          l_num[n_launch] = num_trans;
          l_addr[n_launch] = start_addr;
        end
        n_launch++;
        words_left = int'(num_trans);
      end
      if (frame_done) n_done++;
      if (hold_full && !stall_seen && !px_ready && busy && acc_bytes < 4*total) begin
        stall_seen = 1;
        stall_bytes = acc_bytes;
      end
      indata_req = words_left > 0 && (!hold_full || stall_seen);
      if (indata_req) begin
        if (indata !== exp_word(words_popped)) bad_words++;
        words_popped++;
        words_left--;
        if (words_left == 0) done_pending = 1;
      end
      acc_inc = px_ready;
      tick();
      if (acc_inc) acc_bytes++;
    end
    px_valid = 0; indata_req = 0; dma_done = 0;
  endtask

  initial begin
    logic [7:0] bytes [4];
    bit seen_fd, seen_busy;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1; cfg_start = 0; cfg_base_addr = 0; cfg_total_words = 0;
    px_valid = 0; px_data = 0; dma_done = 0; indata_req = 0;
    tick();
    tick();
    check("rst_start_dma", 32'(start_dma), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_px_ready", 32'(px_ready), 0);
    check("rst_num_trans", 32'(num_trans), 0);
    check("rst_start_addr", start_addr, 0);
    check("rst_indata", indata, 0);
    check("rst_underrun", 32'(underrun_err), 0);
    rst = 0;
    tick();

    // One-word frame: byte packing, ignored restart while busy, single-cycle launch
    cfg_start = 1; cfg_total_words = 1; cfg_base_addr = 32'h0000_2000;
    tick();
    cfg_start = 0;
    check("a_busy", 32'(busy), 1);
    check("a_px_ready", 32'(px_ready), 1);
    for (int i = 0; i < 4; i++) begin
      px_valid = 1;
      px_data = bytes[i];
      cfg_start = i == 1;
      cfg_base_addr = i == 1 ? 32'h0000_9000 : 32'h0000_2000;
      cfg_total_words = i == 1 ? 16'd5 : 16'd1;
      tick();
    end
    px_valid = 0; cfg_start = 0;
    check("a_px_ready_limit", 32'(px_ready), 0);
    wait_launch("a_launch_seen");
    check("a_num_trans", 32'(num_trans), 1);
    check("a_start_addr", start_addr, 32'h0000_2000);
    check("a_indata", indata, 32'h4433_2211);
    indata_req = 1;
    tick();
    indata_req = 0;
    check("a_start_dma_pulse", 32'(start_dma), 0);
    check("a_num_trans_hold", 32'(num_trans), 1);
    dma_done = 1;
    tick();
    dma_done = 0;
    check("a_frame_done", 32'(frame_done), 1);
    tick();
    check("a_frame_done_clr", 32'(frame_done), 0);
    check("a_idle", 32'(busy), 0);

    // 600-word frame: three chunked launches
    run_frame(600, 32'h1000_0000, 0);
    check("b_launches", n_launch, 3);
    check("b_num0", 32'(l_num[0]), 256);
    check("b_addr0", l_addr[0], 32'h1000_0000);
    check("b_num1", 32'(l_num[1]), 256);
    check("b_addr1", l_addr[1], 32'h1000_0400);
    check("b_num2", 32'(l_num[2]), 88);
    check("b_addr2", l_addr[2], 32'h1000_0800);
    check("b_words", words_popped, 600);
    check("b_bad_words", bad_words, 0);
    check("b_bytes", acc_bytes, 2400);
    check("b_frame_done", n_done, 1);
    check("b_idle", 32'(busy) | 32'(frame_done), 0);

    // Empty frame
    cfg_start = 1; cfg_total_words = 0; cfg_base_addr = 32'h5000_0000;
    tick();
    cfg_start = 0;
    check("c_frame_done", 32'(frame_done), 1);
    check("c_no_start_dma", 32'(start_dma), 0);
    tick();
    check("c_frame_done_clr", 32'(frame_done), 0);
    check("c_idle", 32'(busy), 0);

    // FIFO filled to the brim before the DMA starts popping
    run_frame(1000, 32'h2000_0000, 1);
    check("d_stall_seen", 32'(stall_seen), 1);
    check("d_stall_bytes", stall_bytes, 2045);
    check("d_launches", n_launch, 4);
    check("d_num3", 32'(l_num[3]), 232);
    check("d_addr3", l_addr[3], 32'h2000_0C00);
    check("d_words", words_popped, 1000);
    check("d_bad_words", bad_words, 0);
    check("d_frame_done", n_done, 1);

    // Reset during XFER abandons the frame
    cfg_start = 1; cfg_total_words = 4; cfg_base_addr = 32'h0000_3000;
    tick();
    cfg_start = 0;
    for (int i = 0; i < 16; i++) begin
      px_valid = 1;
      px_data = pix(i);
      tick();
    end
    px_valid = 0;
    wait_launch("e_launch_seen");
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("e_busy", 32'(busy), 0);
    check("e_start_dma", 32'(start_dma), 0);
    check("e_frame_done", 32'(frame_done), 0);
    check("e_px_ready", 32'(px_ready), 0);
    check("e_num_trans", 32'(num_trans), 0);
    check("e_start_addr", start_addr, 0);
    check("e_indata", indata, 0);
    dma_done = 1;
    seen_fd = 0; seen_busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      dma_done = 0;
      seen_fd |= frame_done;
      seen_busy |= busy;
    end
    check("e_no_frame_done", 32'(seen_fd), 0);
    check("e_stay_idle", 32'(seen_busy), 0);

`ifdef OFM_FEEDER_UNDERRUN_CHK_EN
    indata_req = 1;
    tick();
    indata_req = 0;
    check("f_underrun_set", 32'(underrun_err), 1);
    check("f_indata_empty", indata, 0);
    tick();
    check("f_underrun_sticky", 32'(underrun_err), 1);
    cfg_start = 1; cfg_total_words = 1; cfg_base_addr = 32'h0000_4000;
    tick();
    cfg_start = 0;
    check("f_underrun_clr", 32'(underrun_err), 0);
    bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      px_valid = 1;
      px_data = bytes[i];
      tick();
    end
    px_valid = 0;
    wait_launch("f_launch_seen");
    check("f_indata", indata, 32'hD4C3_B2A1);
    indata_req = 1;
    tick();
    indata_req = 0;
    dma_done = 1;
    tick();
    dma_done = 0;
    check("f_frame_done", 32'(frame_done), 1);
    tick();
`else
    indata_req = 1;
    tick();
    indata_req = 0;
    check("f_underrun_tied", 32'(underrun_err), 0);
    rst = 1;
    tick();
    rst = 0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
